// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Iterative RV32M multiply/divide unit with its own sequencing FSM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func_3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall
);

    localparam int CW = $clog2(XLEN);
    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode: MULHSU treats only rs1 as signed, MUL/MULHU/DIVU/REMU are unsigned.
    logic            w_is_div, w_a_signed, w_b_signed, w_sa, w_sb, w_neg;
    logic            w_div_zero, w_div_ovf, w_accept;
    logic [XLEN-1:0] w_mag_a, w_mag_b;

    assign w_is_div   = func_3[2];
    assign w_a_signed = func_3[2] ? ~func_3[0] : (func_3[1:0] == 2'b01 || func_3[1:0] == 2'b10);
    assign w_b_signed = func_3[2] ? ~func_3[0] : (func_3[1:0] == 2'b01);
    assign w_sa       = w_a_signed & operand_a[XLEN-1];
    assign w_sb       = w_b_signed & operand_b[XLEN-1];
    assign w_mag_a    = w_sa ? -operand_a : operand_a;
    assign w_mag_b    = w_sb ? -operand_b : operand_b;
    assign w_neg      = (w_is_div & func_3[1]) ? w_sa : (w_sa ^ w_sb);
    assign w_div_zero = w_is_div & (operand_b == '0);
    assign w_div_ovf  = w_is_div & ~func_3[0] & (&operand_b)
                      & (operand_a == {1'b1, {(XLEN-1){1'b0}}});
    assign w_accept   = start & ~flush;

    // One iteration: shift-add for multiply, restoring subtract for divide.
    logic [XLEN:0]   w_sum, w_diff;
    logic [W2-1:0]   w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
    logic [XLEN-1:0] w_div_val, w_div_res, w_final;

    assign w_sum     = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, opnd_q};
    assign w_mul_nxt = acc_q[0] ? {w_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[W2-1:1]};
    assign w_diff    = acc_q[W2-1:XLEN-1] - {1'b0, opnd_q};
    assign w_div_nxt = w_diff[XLEN] ? {acc_q[W2-2:0], 1'b0}
                                    : {w_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign w_acc_nxt = op_q[2] ? w_div_nxt : w_mul_nxt;
    assign w_prod    = neg_q ? -w_acc_nxt : w_acc_nxt;
    assign w_div_val = op_q[1] ? w_acc_nxt[W2-1:XLEN] : w_acc_nxt[XLEN-1:0];
    assign w_div_res = neg_q ? -w_div_val : w_div_val;
    assign w_final   = op_q[2] ? w_div_res
                     : (op_q[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[W2-1:XLEN];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d  = func_3;
                    neg_d = w_neg;
                    cnt_d = CW'(XLEN - 1);
                    if (w_div_zero) begin
                        result_d = func_3[1] ? operand_a : '1;
                        state_d  = S_DONE;
                    end else if (w_div_ovf) begin
                        result_d = func_3[1] ? '0 : operand_a;
                        state_d  = S_DONE;
                    end else begin
                        // Multiply keeps rs2 in the low half and adds rs1; divide shifts rs1 out.
                        opnd_d  = w_is_div ? w_mag_b : w_mag_a;
                        acc_d   = {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = w_acc_nxt;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        result_d = w_final;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign done   = (state_q == S_DONE);
    assign busy   = (state_q != S_IDLE);
    assign stall  = ((state_q == S_IDLE) & w_accept) | (state_q == S_CALC);

endmodule

`default_nettype wire
